// File: rtl/alu_mc.sv
// Multi-cycle ALU with a valid/ready handshake on both sides.
// Single-cycle ops finish in one clock; multiply is a WIDTH-step shift-add sequence.
module alu_mc #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       opcode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             zero
);
    // state | meaning
    // IDLE  | waiting for a request, in_ready high
    // MUL   | shift-add multiply in progress
    // DONE  | result presented, waiting for out_ready
    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH);

    state_t             state;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [CNT_W-1:0]   cnt;

    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     diff;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_carry;

    always_comb begin
        sum       = {1'b0, A} + {1'b0, B};
        diff      = {1'b0, A} - {1'b0, B};
        alu_res   = '0;
        alu_carry = 1'b0;
        case (opcode)
            3'b000: begin
                alu_res   = sum[WIDTH-1:0];
                alu_carry = sum[WIDTH];
            end
            3'b001: begin
                alu_res   = diff[WIDTH-1:0];
                alu_carry = diff[WIDTH];
            end
            3'b010: alu_res = A & B;
            3'b011: alu_res = A | B;
            3'b101: begin
                alu_res   = {A[WIDTH-2:0], 1'b0};
                alu_carry = A[WIDTH-1];
            end
            3'b110: begin
                alu_res   = {1'b0, A[WIDTH-1:1]};
                alu_carry = A[0];
            end
            default: begin
                alu_res   = '0;
                alu_carry = 1'b0;
            end
        endcase
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            result <= '0;
            carry  <= 1'b0;
            zero   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (opcode == 3'b100) begin
                            mcand  <= {{WIDTH{1'b0}}, A};
                            mplier <= B;
                            acc    <= '0;
                            cnt    <= '0;
                            state  <= MUL;
                        end else begin
                            result <= alu_res;
                            carry  <= alu_carry;
                            zero   <= (alu_res == '0);
                            state  <= DONE;
                        end
                    end
                end
                MUL: begin
                    // WIDTH accumulate steps, then one extra cycle to publish the product
                    if (cnt == CNT_LAST) begin
                        result <= acc[WIDTH-1:0];
                        carry  <= |acc[2*WIDTH-1:WIDTH];
                        zero   <= (acc[WIDTH-1:0] == '0);
                        state  <= DONE;
                    end else begin
                        if (mplier[0]) begin
                            acc <= acc + mcand;
                        end
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                        cnt    <= cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_mc.sv
// Bench for alu_mc (WIDTH=8): directed vector table, random ops against an
// arithmetic reference model, and a mid-multiply reset sequence.
module tb_alu_mc;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic [2:0]   opcode = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] result;
    logic         carry;
    logic         zero;

    int checks = 0;
    int errors = 0;

    alu_mc #(.WIDTH(W), .CNT_W(6)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .opcode(opcode), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .carry(carry), .zero(zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] op;
        int         hold;
        logic [7:0] res;
        logic       c;
        logic       z;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Plain arithmetic reference: full-precision integer math, then truncate.
    task automatic model(input int unsigned a, input int unsigned b, input int op,
                         output logic [7:0] res, output logic c, output logic z);
        int unsigned full;
        full = 0;
        c = 1'b0;
        case (op)
            0: begin full = a + b; c = (full > 255); end
            1: begin full = (a + 256 - b) % 256; c = (a < b); end
            2: full = a & b;
            3: full = a | b;
            4: begin full = a * b; c = (full / 256) != 0; end
            5: begin full = a * 2; c = (a >= 128); end
            6: begin full = a / 2; c = (a % 2) == 1; end
            default: full = 0;
        endcase
        res = 8'(full % 256);
        z = (res == 0);
    endtask

    // Called at a negedge with the block idle; returns at a negedge with it idle again.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                          input int hold, input logic [7:0] er, input logic ec, input logic ez);
        int  lat;
        bit  done;
        chk("in_ready_before", int'(in_ready), 1);
        in_valid  = 1'b1;
        A         = a;
        B         = b;
        opcode    = op;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'(($urandom % 2));
        A        = 8'($urandom);
        B        = 8'($urandom);
        opcode   = 3'($urandom);
        lat  = 0;
        done = 0;
        while (!done && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (out_valid) begin
                done = 1;
            end else begin
                chk("in_ready_busy", int'(in_ready), 0);
                in_valid  = 1'(($urandom % 2));
                A         = 8'($urandom);
                B         = 8'($urandom);
                opcode    = 3'($urandom);
                out_ready = 1'(($urandom % 2));
            end
        end
        chk("latency", lat, (op == 3'b100) ? W + 1 : 1);
        if (!done) return;
        chk("result", int'(result), int'(er));
        chk("carry", int'(carry), int'(ec));
        chk("zero", int'(zero), int'(ez));
        out_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'(($urandom % 2));
            A        = 8'($urandom);
            @(negedge clk);
            chk("hold_valid", int'(out_valid), 1);
            chk("hold_result", int'(result), int'(er));
            chk("hold_carry", int'(carry), int'(ec));
            chk("hold_in_ready", int'(in_ready), 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("idle_out_valid", int'(out_valid), 0);
        chk("idle_in_ready", int'(in_ready), 1);
        out_ready = 1'b0;
    endtask

    vec_t vecs[12];

    initial begin
        logic [7:0] er;
        logic       ec;
        logic       ez;
        logic [7:0] ra;
        logic [7:0] rb;
        logic [2:0] rop;

        vecs[0]  = '{8'hF0, 8'h20, 3'b000, 0, 8'h10, 1'b1, 1'b0};
        vecs[1]  = '{8'h05, 8'h05, 3'b001, 1, 8'h00, 1'b0, 1'b1};
        vecs[2]  = '{8'h03, 8'h05, 3'b001, 0, 8'hFE, 1'b1, 1'b0};
        vecs[3]  = '{8'h10, 8'h11, 3'b100, 0, 8'h10, 1'b1, 1'b0};
        vecs[4]  = '{8'h0C, 8'h0A, 3'b100, 2, 8'h78, 1'b0, 1'b0};
        vecs[5]  = '{8'h81, 8'h00, 3'b101, 5, 8'h02, 1'b1, 1'b0};
        vecs[6]  = '{8'hF0, 8'h3C, 3'b010, 0, 8'h30, 1'b0, 1'b0};
        vecs[7]  = '{8'h0F, 8'hF0, 3'b011, 0, 8'hFF, 1'b0, 1'b0};
        vecs[8]  = '{8'h03, 8'h00, 3'b110, 0, 8'h01, 1'b1, 1'b0};
        vecs[9]  = '{8'h5A, 8'hA5, 3'b111, 1, 8'h00, 1'b0, 1'b1};
        vecs[10] = '{8'hFF, 8'hFF, 3'b100, 0, 8'h01, 1'b1, 1'b0};
        vecs[11] = '{8'h00, 8'h9C, 3'b100, 0, 8'h00, 1'b0, 1'b1};

        #1 rst_n = 1'b0;
        #1;
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_result", int'(result), 0);
        chk("rst_carry", int'(carry), 0);
        chk("rst_zero", int'(zero), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i])
            run_op(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].hold,
                   vecs[i].res, vecs[i].c, vecs[i].z);

        // Reset in the 4th multiply cycle aborts the operation with no clock needed.
        in_valid = 1'b1;
        A        = 8'h10;
        B        = 8'h11;
        opcode   = 3'b100;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_out_valid", int'(out_valid), 0);
        chk("abort_result", int'(result), 0);
        chk("abort_in_ready", int'(in_ready), 1);
        chk("abort_carry", int'(carry), 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("no_spurious_valid", int'(out_valid), 0);
        end

        for (int n = 0; n < 40; n++) begin
            ra  = 8'($urandom);
            rb  = 8'($urandom);
            rop = (n % 4 == 0) ? 3'b100 : 3'($urandom);
            model(int'(ra), int'(rb), int'(rop), er, ec, ez);
            run_op(ra, rb, rop, int'($urandom_range(0, 3)), er, ec, ez);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/alu_mc.md
ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits (legal range 4..32).
REQ-002 SHALL have parameter CNT_W, default 6, multiply iteration-counter width; must satisfy 2^CNT_W > WIDTH.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  operation request valid.
REQ-006 SHALL have port in_ready  output  1  block can accept a request.
REQ-007 SHALL have port A  input  WIDTH  operand A.
REQ-008 SHALL have port B  input  WIDTH  operand B.
REQ-009 SHALL have port opcode  input  3  operation select.
REQ-010 SHALL have port out_valid  output  1  result valid.
REQ-011 SHALL have port out_ready  input  1  consumer accepts result.
REQ-012 SHALL have port result  output  WIDTH  registered result.
REQ-013 SHALL have port carry  output  1  registered carry/borrow/overflow flag.
REQ-014 SHALL have port zero  output  1  registered flag, 1 when result == 0.

Function
REQ-015 SHALL support opcodes: 000 A+B, 001 A-B, 010 A&B, 011 A|B, 100 A*B, 101 A<<1, 110 A>>1 (logical), 111 result 0.
REQ-016 SHALL implement an FSM with states IDLE, MUL, DONE.
REQ-017 SHALL assert in_ready only in IDLE; a request is accepted when in_valid && in_ready at a rising edge.
REQ-018 SHALL capture A, B, opcode on acceptance; later input changes SHALL have no effect on the operation in flight.
REQ-019 On acceptance of any non-multiply opcode: compute, register result/carry/zero, go to DONE next cycle (out_valid 1 cycle after acceptance).
REQ-020 On acceptance of opcode 100: go to MUL, clear 2*WIDTH-bit accumulator and counter; perform one shift-add step per cycle for exactly WIDTH cycles, then register outputs and go to DONE (out_valid WIDTH+1 cycles after acceptance).
REQ-021 Multiply: result = low WIDTH bits of the full product; carry = 1 iff upper WIDTH bits of product nonzero.
REQ-022 Add: result = (A+B) mod 2^WIDTH; carry = carry-out bit WIDTH.
REQ-023 Sub: result = (A-B) mod 2^WIDTH; carry = 1 iff A < B (unsigned borrow).
REQ-024 Shift-left: carry = A[WIDTH-1]; shift-right: carry = A[0]; AND, OR, 111: carry = 0.
REQ-025 zero SHALL equal (result == 0) for every opcode, including 111 (zero = 1).
REQ-026 In DONE: out_valid = 1; result/carry/zero SHALL hold stable until out_valid && out_ready, after which FSM returns to IDLE next cycle.
REQ-027 out_ready SHALL be ignored outside DONE; in_valid SHALL be ignored outside IDLE.
REQ-028 Back-pressure: out_ready held low SHALL keep DONE indefinitely with no output change.
REQ-029 Minimum turnaround: new request accepted no earlier than the cycle after the output handshake.

Reset
REQ-030 rst_n low SHALL immediately (no clock) force IDLE, in_ready = 1, out_valid = 0, result = 0, carry = 0, zero = 0, counter and accumulator = 0.
REQ-031 Reset asserted mid-multiply or in DONE SHALL abort the operation; no out_valid SHALL follow reset release without a new request.
REQ-032 First acceptance possible on the first rising edge after rst_n deasserts.

Verification (WIDTH=8)
REQ-033 Add: A=0xF0, B=0x20, op 000 -> 1 cycle later out_valid, result 0x10, carry 1, zero 0.
REQ-034 Sub: A=0x05, B=0x05, op 001 -> result 0x00, carry 0, zero 1; A=0x03, B=0x05 -> result 0xFE, carry 1.
REQ-035 Mul: A=0x10, B=0x11, op 100 -> out_valid exactly 9 cycles after acceptance, result 0x10, carry 1; A=0x0C, B=0x0A -> 0x78, carry 0; in_ready 0 throughout.
REQ-036 Back-pressure: A=0x81, op 101, out_ready low 5 cycles -> result 0x02, carry 1 held stable; in_valid pulses ignored; IDLE one cycle after out_ready rises.
REQ-037 Reset at 4th MUL cycle -> out_valid 0, result 0, in_ready 1 immediately; no spurious out_valid after release.
REQ-038 Operand change: A/B/opcode altered during MUL -> result matches operands captured at acceptance.
